// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM status, data words and the arbiter's state and grant records.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbstate_t;

  // Wide enough for any practical core count; the arbiter uses only the low bits it needs.
  localparam int CORE_W = 8;

  typedef struct packed {
    logic [CORE_W-1:0] core;
    logic              isData;
  } arbgrant_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin pick: first asserted request at or after rr_i, wrapping from N-1 to 0.
module rr_select #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] rr_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  localparam int SW = W + 1;

  logic [W:0] cand_s;

  // Scan from the farthest offset down so the candidate closest to rr_i is written last and wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    cand_s  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s  = {1'b0, rr_i} + SW'(k);
      cand_s  = (cand_s >= SW'(N)) ? (cand_s - SW'(N)) : cand_s;
      idx_o   = req_i[cand_s[W-1:0]] ? cand_s[W-1:0] : idx_o;
      valid_o = valid_o | req_i[cand_s[W-1:0]];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shared-RAM arbiter for per-core icache/dcache miss traffic: one word transaction per grant,
// data before instruction, round-robin over cores within each class.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic      [CPUS-1:0] iREN,
  input  word_t     [CPUS-1:0] iaddr,
  output logic      [CPUS-1:0] iwait,
  output word_t     [CPUS-1:0] iload,
  input  logic      [CPUS-1:0] dREN,
  input  logic      [CPUS-1:0] dWEN,
  input  word_t     [CPUS-1:0] daddr,
  input  word_t     [CPUS-1:0] dstore,
  output logic      [CPUS-1:0] dwait,
  output word_t     [CPUS-1:0] dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate
);

  localparam int IDXW = (CPUS > 1) ? $clog2(CPUS) : 1;

  arbstate_t       state_q, state_d;
  logic [IDXW-1:0] rr_q, rr_d;
  arbgrant_t       grant_q, grant_d;

  logic [CPUS-1:0] dreq_s;
  logic [IDXW-1:0] d_idx_s, i_idx_s;
  logic            d_valid_s, i_valid_s;
  logic [IDXW-1:0] gcore_s;
  logic [IDXW-1:0] rr_next_s;
  logic            live_s;
  logic            done_s;
  logic            unused_core_hi_s;

  assign dreq_s  = dREN | dWEN;
  assign gcore_s = grant_q.core[IDXW-1:0];
  assign unused_core_hi_s = ^grant_q.core;

  rr_select #(.N(CPUS), .W(IDXW)) u_sel_data (
    .req_i   (dreq_s),
    .rr_i    (rr_q),
    .idx_o   (d_idx_s),
    .valid_o (d_valid_s)
  );

  rr_select #(.N(CPUS), .W(IDXW)) u_sel_inst (
    .req_i   (iREN),
    .rr_i    (rr_q),
    .idx_o   (i_idx_s),
    .valid_o (i_valid_s)
  );

  // A grant completes only while its request is still up; a dropped request is a withdrawal.
  assign live_s    = grant_q.isData ? dreq_s[gcore_s] : iREN[gcore_s];
  assign done_s    = (state_q == GRANT) && live_s && (ramstate == ACCESS);
  assign rr_next_s = (gcore_s == IDXW'(CPUS - 1)) ? '0 : (gcore_s + IDXW'(1));

  // Next-state, pointer and grant-latch decisions.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (d_valid_s) begin
          grant_d.core   = CORE_W'(d_idx_s);
          grant_d.isData = 1'b1;
          state_d        = GRANT;
        end else if (i_valid_s) begin
          grant_d.core   = CORE_W'(i_idx_s);
          grant_d.isData = 1'b0;
          state_d        = GRANT;
        end else begin
          grant_d = '0;
        end
      end
      GRANT: begin
        if (done_s) begin
          state_d = IDLE;
          rr_d    = rr_next_s;
          grant_d = '0;
        end else if (!live_s) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, round-robin pointer and grant latch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  // RAM port mux and wait generation from the latched winner; write wins over read.
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (state_q == GRANT) begin
      if (grant_q.isData) begin
        ramaddr        = daddr[gcore_s];
        ramstore       = dstore[gcore_s];
        ramWEN         = dWEN[gcore_s];
        ramREN         = dREN[gcore_s] & ~dWEN[gcore_s];
        dwait[gcore_s] = ~done_s;
      end else begin
        ramaddr        = iaddr[gcore_s];
        ramREN         = iREN[gcore_s];
        iwait[gcore_s] = ~done_s;
      end
    end else begin
      ramaddr = '0;
    end
  end

  // Load data is broadcast; only the requester whose wait is low treats it as valid.
  always_comb begin
    for (int c = 0; c < CPUS; c++) begin
      iload[c] = ramload;
      dload[c] = ramload;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected RAM transactions plus cycle-level checks.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 2;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [1:0]       iREN, dREN, dWEN, iwait, dwait;
  word_t [1:0]      iaddr, daddr, dstore, iload, dload;
  logic             ramREN, ramWEN;
  word_t            ramaddr, ramstore, ramload;
  ramstate_t        ramstate;

  mem_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] id;      // core*2 + isData
    word_t      addr;
    word_t      store;
    word_t      load;
    logic       wen;
    logic       ren;
  } txn_t;

  txn_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   rr_m   = 0;

  function automatic txn_t mk(input int id, input word_t addr, input word_t store,
                              input logic wen, input logic ren, input word_t load);
    txn_t t;
    t.id = 8'(id); t.addr = addr; t.store = store; t.load = load; t.wen = wen; t.ren = ren;
    return t;
  endfunction

  function automatic logic id_low(input int id);
    logic c;
    c = id[1];
    return id[0] ? ~dwait[c] : ~iwait[c];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic await_done(input string tag, input int id, input int max_cyc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge CLK);
      ok = id_low(id);
    end
    n_cmp++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s: observed no wait-low for id %0d expected completion within %0d cycles",
             tag, id, max_cyc);
    end
  endtask

  // Scoreboard: every completion (any wait low) must match the oldest expected transaction.
  always @(negedge CLK) begin
    txn_t o, e;
    int   id;
    if (nRST === 1'b1 && ((~iwait | ~dwait) != 2'b00)) begin
      if (!dwait[0])      id = 1;
      else if (!dwait[1]) id = 3;
      else if (!iwait[0]) id = 0;
      else                id = 2;
      o = mk(id, ramaddr, ramstore, ramWEN, ramREN, id[0] ? dload[id[1]] : iload[id[1]]);
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed completion id %0d expected none", id);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        assert (o === e) else begin
          n_fail++;
          $error("FAIL sb_txn: observed %h expected %h", o, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    word_t a3 [2];
    word_t s3 [2];
    int    core, w, o;
    logic  wb, ob;

    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

    // Reset state
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_iwait", 64'(iwait), 64'h3);
    chk("rst_dwait", 64'(dwait), 64'h3);
    chk("rst_ren", 64'(ramREN), 64'h0);
    chk("rst_wen", 64'(ramWEN), 64'h0);
    chk("rst_addr", 64'(ramaddr), 64'h0);
    chk("rst_store", 64'(ramstore), 64'h0);
    tick();
    nRST = 1'b1;

    // Single dcache read answered on the first grant cycle
    dREN[0] = 1'b1; daddr[0] = 32'h100; ramstate = ACCESS; ramload = 32'hDEADBEEF;
    sb.push_back(mk(1, 32'h100, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF));
    @(negedge CLK);
    chk("t1_c0_ren", 64'(ramREN), 64'h0);
    await_done("t1_done", 1, 1);
    chk("t1_c1_ren", 64'(ramREN), 64'h1);
    chk("t1_c1_addr", 64'(ramaddr), 64'h100);
    chk("t1_c1_dload", 64'(dload[0]), 64'hDEADBEEF);
    tick();
    dREN[0] = 1'b0;
    @(negedge CLK);
    chk("t1_c2_ren", 64'(ramREN), 64'h0);
    chk("t1_c2_dwait", 64'(dwait), 64'h3);
    rr_m = 1;

    // Data beats instruction
    tick();
    ramstate = BUSY; ramload = 32'h11112222;
    iREN[0] = 1'b1; iaddr[0] = 32'h200; dREN[1] = 1'b1; daddr[1] = 32'h300;
    sb.push_back(mk(3, 32'h300, 32'h0, 1'b0, 1'b1, 32'h11112222));
    sb.push_back(mk(0, 32'h200, 32'h0, 1'b0, 1'b1, 32'h11112222));
    @(negedge CLK);
    chk("t2_idle_ren", 64'(ramREN), 64'h0);
    tick();
    @(negedge CLK);
    chk("t2_grant_addr", 64'(ramaddr), 64'h300);
    chk("t2_busy_iwait", 64'(iwait), 64'h3);
    chk("t2_busy_dwait", 64'(dwait), 64'h3);
    tick();
    ramstate = ACCESS;
    await_done("t2_d1_done", 3, 1);
    chk("t2_iwait0_held", 64'(iwait[0]), 64'h1);
    tick();
    dREN[1] = 1'b0;
    @(negedge CLK);
    chk("t2_gap_ren", 64'(ramREN), 64'h0);
    chk("t2_gap_iwait0", 64'(iwait[0]), 64'h1);
    await_done("t2_i0_done", 0, 1);
    chk("t2_i0_addr", 64'(ramaddr), 64'h200);
    tick();
    iREN[0] = 1'b0;
    rr_m = 1;

    // Round-robin between two continuous writers, ACCESS after two BUSY cycles
    a3[0] = 32'h400; a3[1] = 32'h500; s3[0] = 32'hA0; s3[1] = 32'hB1;
    dWEN = 2'b11; daddr[0] = a3[0]; daddr[1] = a3[1]; dstore[0] = s3[0]; dstore[1] = s3[1];
    ramstate = BUSY; ramload = 32'h33334444;
    for (int k = 0; k < 4; k++) begin
      core = (rr_m + k) % 2;
      sb.push_back(mk(core * 2 + 1, a3[core], s3[core], 1'b1, 1'b0, 32'h33334444));
    end
    for (int k = 0; k < 4; k++) begin
      core = (rr_m + k) % 2;
      tick();
      @(negedge CLK);
      chk("t3_store", 64'(ramstore), 64'(s3[core]));
      chk("t3_wen", 64'(ramWEN), 64'h1);
      tick();
      tick();
      ramstate = ACCESS;
      await_done("t3_done", core * 2 + 1, 1);
      tick();
      ramstate = BUSY;
    end
    dWEN = 2'b00;

    // Simultaneous read and write from one dcache: write wins
    tick();
    dREN[0] = 1'b1; dWEN[0] = 1'b1; dstore[0] = 32'h55; daddr[0] = 32'h600;
    ramstate = ACCESS; ramload = 32'h5555AAAA;
    sb.push_back(mk(1, 32'h600, 32'h55, 1'b1, 1'b0, 32'h5555AAAA));
    await_done("t4_done", 1, 2);
    chk("t4_wen", 64'(ramWEN), 64'h1);
    chk("t4_ren", 64'(ramREN), 64'h0);
    chk("t4_store", 64'(ramstore), 64'h55);
    tick();
    dREN[0] = 1'b0; dWEN[0] = 1'b0;
    rr_m = 1;

    // Withdrawal during BUSY leaves rr alone; a following contest starts at rr
    tick();
    w = rr_m; o = 1 - w; wb = w[0]; ob = o[0];
    dstore = '0; ramstate = BUSY;
    dREN[wb] = 1'b1; daddr[wb] = 32'h700;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("t5_ren", 64'(ramREN), 64'h1);
    tick();
    dREN[wb] = 1'b0;
    @(negedge CLK);
    chk("t5_drop_ren", 64'(ramREN), 64'h0);
    chk("t5_drop_dwait", 64'(dwait), 64'h3);
    tick();
    @(negedge CLK);
    chk("t5_idle_addr", 64'(ramaddr), 64'h0);
    tick();
    dREN = 2'b11; daddr[0] = 32'h800; daddr[1] = 32'h900;
    ramstate = ACCESS; ramload = 32'h77778888;
    sb.push_back(mk(w * 2 + 1, daddr[wb], 32'h0, 1'b0, 1'b1, 32'h77778888));
    sb.push_back(mk(o * 2 + 1, daddr[ob], 32'h0, 1'b0, 1'b1, 32'h77778888));
    await_done("t5_first", w * 2 + 1, 2);
    tick();
    dREN[wb] = 1'b0;
    await_done("t5_second", o * 2 + 1, 2);
    tick();
    dREN = 2'b00;

    // Asynchronous reset in the middle of a grant
    tick();
    ramstate = BUSY;
    iREN[1] = 1'b1; iaddr[1] = 32'hA00; dREN[0] = 1'b1; daddr[0] = 32'hB00;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    chk("t6_ren", 64'(ramREN), 64'h1);
    chk("t6_addr", 64'(ramaddr), 64'hB00);
    #2;
    nRST = 1'b0;
    #1;
    chk("t6_rst_ren", 64'(ramREN), 64'h0);
    chk("t6_rst_wen", 64'(ramWEN), 64'h0);
    chk("t6_rst_dwait", 64'(dwait), 64'h3);
    chk("t6_rst_iwait", 64'(iwait), 64'h3);
    tick();
    dREN[0] = 1'b0;
    tick();
    nRST = 1'b1; ramstate = ACCESS; ramload = 32'h9999;
    sb.push_back(mk(2, 32'hA00, 32'h0, 1'b0, 1'b1, 32'h9999));
    await_done("t6_i1_done", 2, 2);
    tick();
    iREN[1] = 1'b0;

    tick();
    @(negedge CLK);
    chk("end_sb_empty", 64'(sb.size()), 64'h0);
    chk("end_iwait", 64'(iwait), 64'h3);
    chk("end_dwait", 64'(dwait), 64'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the per-core instruction and data cache miss traffic onto the single shared RAM port. Sits directly downstream of every icache/dcache pair. It consumes the caches' request signals (`iREN`, `dREN`, `dWEN`, addresses, store data) and returns `iwait`/`dwait` and load data. It grants one word transaction at a time and holds that grant until RAM reports completion.

## Interface
- `CPUS`, default 2, number of cores (each core has one icache and one dcache requester); must be ≥1
- `CLK`  in  1  system clock
- `nRST`  in  1  asynchronous active-low reset
- `iREN`  in  CPUS  icache read request per core
- `iaddr`  in  CPUS×32  icache word address per core
- `iwait`  out  CPUS  icache stall per core
- `iload`  out  CPUS×32  icache read data per core
- `dREN`, `dWEN`  in  CPUS each  dcache read and write requests per core
- `daddr`, `dstore`  in  CPUS×32 each  dcache address and write data per core
- `dwait`  out  CPUS  dcache stall per core
- `dload`  out  CPUS×32  dcache read data per core
- `ramREN`, `ramWEN`  out  1 each  RAM read and write strobes
- `ramaddr`, `ramstore`  out  32 each  RAM address and write data
- `ramload`  in  32  RAM read data
- `ramstate`  in  ramstate_t  RAM status: FREE, BUSY, ACCESS, ERROR

## Operation
- FSM states:
  - IDLE: no grant held; RAM strobes low.
  - GRANT: one requester latched; its signals are muxed to the RAM port.
- IDLE → GRANT when any request line is high. The winner is latched as the pair `{core, isData}`.
- Selection rule:
  - Data requests beat instruction requests.
  - Within a class, scan cores starting at round-robin pointer `rr`, wrapping at CPUS−1 → 0.
- GRANT, driven from the latched winner:
  - `ramaddr` is the granted address.
  - `ramstore` is the granted `dstore`, or 0 for an icache grant.
  - `ramWEN` = `dWEN`; `ramREN` = `(dREN|iREN) & ~dWEN`. If `dREN` and `dWEN` are both high, the write wins.
- Completion is the cycle in GRANT where `ramstate==ACCESS` and the granted request is still high:
  - The granted wait is driven low combinationally in that cycle.
  - Next edge: go to IDLE and set `rr` = (granted core + 1) mod CPUS.
- Withdrawal: if the granted request drops while in GRANT, go to IDLE next edge. This does not count as a completion, and `rr` is unchanged.
- `ramstate` BUSY, FREE or ERROR while in GRANT: hold the grant and keep wait high. ERROR is not escalated.
- Load data: `iload[c]` and `dload[c]` equal `ramload` for every c. Data is valid only when the matching wait is low.
- All non-granted waits are 1 at all times.
- No burst lock:
  - A dcache two-word fill is two independent grants.
  - Another requester may win between them, because the dcache drops `dREN` for one cycle between words.

## Timing
- Reset, asynchronous: state=IDLE, `rr`=0, latched grant cleared.
  - All waits = 1; `ramREN`/`ramWEN` = 0; `ramaddr`/`ramstore` = 0.
  - Asserting `nRST` mid-GRANT drops the RAM strobes immediately; no completion is signalled.
- Request first seen in cycle N in IDLE:
  - The grant registers at edge N+1.
  - RAM strobes are asserted during cycle N+1.
  - The earliest wait-low is cycle N+1, if RAM answers ACCESS in that cycle.
- The arbiter always passes through one IDLE cycle between grants. Minimum 2 cycles per transaction.
- The grant decision uses registered state plus current request lines only. There is no combinational path from `ramload` to any wait.
- Simultaneous `iREN[c]` and `dREN[c]` from the same core: the dcache is served first. The icache is served in a later grant, subject to `rr`.

## Structure
- `ramstate_t` and `word_t` come from `cpu_types_pkg`.
- Add to `cpu_types_pkg`: arbiter state enum `arbstate_t` {IDLE, GRANT}, and grant struct `arbgrant_t` {core index, isData}.
- Make the winner selection a combinational sub-module `rr_select`. Inputs: request vector, `rr`. Outputs: winner index and valid. One instance for data, one for instruction.
- The top level holds the FSM, `rr`, the grant latch and the output muxes. Roughly 150–250 lines.

## Test plan
- Reset, then single `dREN[0]`, `daddr[0]`=0x100, `ramstate` ACCESS on the first GRANT cycle, `ramload`=0xDEADBEEF:
  - `ramREN`=1 and `ramaddr`=0x100 in cycle 1.
  - `dwait[0]`=0 and `dload[0]`=0xDEADBEEF in that cycle.
  - IDLE at cycle 2.
- Priority: `iREN[0]` and `dREN[1]` asserted together → core 1 data granted first. `iwait[0]` stays 1 until core 1 completes, then `iaddr[0]` is granted after one IDLE cycle.
- Round-robin: `dWEN[0]` and `dWEN[1]` held continuously, RAM ACCESS after 2 BUSY cycles → grants alternate 0,1,0,1 with `ramstore` tracking `dstore` of the granted core.
- `dREN[0]` and `dWEN[0]` both high with `dstore[0]`=0x55 → `ramWEN`=1, `ramREN`=0, `ramstore`=0x55.
- Withdrawal: `dREN[0]` dropped while `ramstate`=BUSY → IDLE next cycle, no wait-low pulse, `rr` still 0.
- `nRST` pulsed low mid-GRANT → `ramREN`/`ramWEN` go 0 and all waits go 1 asynchronously; after release, a pending `iREN[1]` is granted.
